// File: rtl/cnn_pkg.sv
// Shared widths, FSM state type and the output clamp for the 3x3 convolution slice.
package cnn_pkg;

    localparam int DATA_W    = 16;
    localparam int PROD_W    = 32;
    localparam int ACC_W     = 36;
    localparam int OUT_W     = 32;
    localparam int KER       = 3;
    localparam int NTAP      = KER * KER;
    localparam int CNT_W     = 8;
    localparam int PIPE_D    = 4;
    localparam int DRAIN_CYC = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // Per-sample bookkeeping that travels alongside the datapath.
    typedef struct packed {
        logic             srt;
        logic             valid;
        logic [CNT_W-1:0] row;
        logic [CNT_W-1:0] col;
    } tag_t;

    // The accumulator fits OUT_W bits only when its top bits are a pure sign extension.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] acc);
        logic [ACC_W-OUT_W:0] top;
        top = acc[ACC_W-1:OUT_W-1];
        if (top == '0 || top == '1) begin
            sat_out = acc[OUT_W-1:0];
        end else if (acc[ACC_W-1]) begin
            sat_out = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_out = {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/conv3x3_sa_if.sv
// Row-feeder, weight-load and result bus of the 3x3 convolution engine.
interface conv3x3_sa_if;
    import cnn_pkg::*;

    logic                     srt_in;
    logic signed [DATA_W-1:0] in1;
    logic signed [DATA_W-1:0] in2;
    logic signed [DATA_W-1:0] in3;
    logic                     w_we;
    logic signed [DATA_W-1:0] w_in;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic [CNT_W-1:0]         out_row;
    logic [CNT_W-1:0]         out_col;
    logic                     done;

    modport master (
        output srt_in, in1, in2, in3, w_we, w_in,
        input  out_valid, out_data, out_row, out_col, done
    );

    modport slave (
        input  srt_in, in1, in2, in3, w_we, w_in,
        output out_valid, out_data, out_row, out_col, done
    );

endinterface

// File: rtl/sa_pe.sv
// Processing element: one registered signed 16x16 multiply.
module sa_pe
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [PROD_W-1:0] prod
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
        end else begin
            prod <= PROD_W'(a) * PROD_W'(b);
        end
    end

endmodule

// File: rtl/conv3x3_sa.sv
// Streaming 3x3 convolution: three skewed row lanes in, one saturated result per column out.
module conv3x3_sa
    import cnn_pkg::*;
#(
    parameter int SIZE = 7,
    parameter int PAD  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    conv3x3_sa_if.slave bus
);

    localparam int I_SIZE = SIZE + 2 * PAD;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(I_SIZE - 1);
    localparam logic [CNT_W-1:0] BAND_END = CNT_W'(I_SIZE - 2);
    localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYC - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] col_reg, col_next;
    logic [CNT_W-1:0] band_reg, band_next;
    logic [1:0]       drain_reg, drain_next;
    logic             done_next;
    logic             take;

    logic [3:0]               widx_reg, widx_next;
    logic                     w_accept;
    logic signed [DATA_W-1:0] w_reg [NTAP];

    logic signed [DATA_W-1:0] d1a_reg, d1b_reg, d2_reg;
    logic signed [DATA_W-1:0] lane [KER];
    logic signed [DATA_W-1:0] tap_reg [KER][KER];

    tag_t tag_in;
    tag_t tag_reg [PIPE_D];

    logic signed [PROD_W-1:0] prod [NTAP];
    logic signed [ACC_W-1:0]  acc;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            col_reg   <= '0;
            band_reg  <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            band_reg  <= band_next;
            drain_reg <= drain_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        band_next  = band_reg;
        drain_next = drain_reg;
        done_next  = 1'b0;
        take       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.srt_in) begin
                    state_next = ST_RUN;
                    take       = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.srt_in || band_reg == BAND_END) begin
                    state_next = ST_DRAIN;
                    drain_next = '0;
                end else begin
                    take = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    col_next   = '0;
                    band_next  = '0;
                end else begin
                    drain_next = drain_reg + 2'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (take) begin
            if (col_reg == COL_LAST) begin
                col_next  = '0;
                band_next = band_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // ---------------- kernel weights ----------------
    assign w_accept  = bus.w_we && (state_reg == ST_IDLE);
    assign widx_next = (widx_reg == 4'(NTAP - 1)) ? 4'd0 : widx_reg + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx_reg <= '0;
            for (int i = 0; i < NTAP; i++) begin
                w_reg[i] <= '0;
            end
        end else if (w_accept) begin
            w_reg[widx_reg] <= bus.w_in;
            widx_reg        <= widx_next;
        end
    end

    // ---------------- lane de-skew and column taps ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1a_reg <= '0;
            d1b_reg <= '0;
            d2_reg  <= '0;
        end else begin
            d1a_reg <= bus.in1;
            d1b_reg <= d1a_reg;
            d2_reg  <= bus.in2;
        end
    end

    always_comb begin
        lane[0] = d1b_reg;
        lane[1] = d2_reg;
        lane[2] = bus.in3;
    end

    // Taps shift only when an aligned column is present, so srt_in gaps do not smear columns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KER; i++) begin
                for (int j = 0; j < KER; j++) begin
                    tap_reg[i][j] <= '0;
                end
            end
        end else if (tag_reg[1].srt) begin
            for (int i = 0; i < KER; i++) begin
                tap_reg[i][0] <= lane[i];
                for (int j = 1; j < KER; j++) begin
                    tap_reg[i][j] <= tap_reg[i][j-1];
                end
            end
        end
    end

    // ---------------- sample tag pipeline ----------------
    always_comb begin
        tag_in       = '0;
        tag_in.srt   = take;
        tag_in.valid = take && (col_reg >= CNT_W'(2));
        tag_in.row   = band_reg;
        tag_in.col   = col_reg - CNT_W'(2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_D; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= tag_in;
            for (int i = 1; i < PIPE_D; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    // ---------------- multiplier array ----------------
    // tap 0 holds the newest column, so kernel column j reads tap KER-1-j.
    for (genvar gi = 0; gi < NTAP; gi++) begin : g_pe
        localparam int LI = gi / KER;
        localparam int LJ = gi % KER;
        sa_pe u_pe (
            .clk  (clk),
            .rst_n(rst_n),
            .a    (w_reg[gi]),
            .b    (tap_reg[LI][KER-1-LJ]),
            .prod (prod[gi])
        );
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NTAP; i++) begin
            acc = acc + ACC_W'(prod[i]);
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.out_valid <= tag_reg[PIPE_D-1].valid;
            bus.done      <= done_next;
            if (tag_reg[PIPE_D-1].valid) begin
                bus.out_data <= sat_out(acc);
                bus.out_row  <= tag_reg[PIPE_D-1].row;
                bus.out_col  <= tag_reg[PIPE_D-1].col;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_sa.sv
// Directed bench for conv3x3_sa on a 5x5 frame: identity, ones, saturation, reset abort, weight wrap, RUN-time writes.
module tb_conv3x3_sa;
    import cnn_pkg::*;

    localparam int SIZE   = 5;
    localparam int PAD    = 0;
    localparam int I_SIZE = SIZE + 2 * PAD;
    localparam int NB     = I_SIZE - 2;
    localparam int NOUT   = NB * NB;

    localparam int K_IDENT = 0;
    localparam int K_ONES  = 1;
    localparam int K_SATP  = 2;
    localparam int K_SATN  = 3;
    localparam int K_WLOAD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv3x3_sa_if bus ();

    conv3x3_sa #(.SIZE(SIZE), .PAD(PAD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t1_tab [64];

    int    q_cyc [$];
    longint q_data [$];
    int    q_row [$];
    int    q_col [$];
    int    done_cyc [$];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_cyc.delete(); q_data.delete(); q_row.delete(); q_col.delete(); done_cyc.delete();
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid) begin
            q_cyc.push_back(cyc);
            q_data.push_back(longint'(bus.out_data));
            q_row.push_back(int'(bus.out_row));
            q_col.push_back(int'(bus.out_col));
        end
        if (bus.done) done_cyc.push_back(cyc);
    endtask

    task automatic idle_inputs();
        bus.srt_in = 1'b0;
        bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
        bus.w_we = 1'b0; bus.w_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        clear_q();
    endtask

    task automatic write_word(input int v);
        bus.w_we = 1'b1;
        bus.w_in = 16'(v);
        step();
        bus.w_we = 1'b0;
    endtask

    task automatic load_const(input int v);
        for (int i = 0; i < NTAP; i++) write_word(v);
    endtask

    task automatic load_ident();
        for (int i = 0; i < NTAP; i++) write_word((i == 4) ? 1 : 0);
    endtask

    function automatic logic signed [15:0] pix(input int mode, input int r, input int c);
        case (mode)
            0: pix = 16'(10 * r + c);
            1: pix = 16'sd1;
            default: pix = 16'sd32767;
        endcase
    endfunction

    function automatic longint exp_out(input int kind, input int r, input int c);
        case (kind)
            K_IDENT: exp_out = 10 * (r + 1) + (c + 1);
            K_ONES:  exp_out = 9;
            K_SATP:  exp_out = 64'sd2147483647;
            K_SATN:  exp_out = -64'sd2147483648;
            default: exp_out = 54 * (10 * r + c) + 681;
        endcase
    endfunction

    // Streams NB bands of I_SIZE columns; abort_slot >= 0 pulses rst_n low there and stops feeding.
    task automatic run_frame(input int mode, input int abort_slot, input bit junk_we);
        int total;
        int ns;
        total = NB * I_SIZE + 2;
        ns = NB * I_SIZE;
        clear_q();
        for (int s = 0; s < total; s++) begin
            if (s == abort_slot) begin
                idle_inputs();
                rst_n = 1'b0;
                clear_q();
                step();
                rst_n = 1'b1;
                check_val("abort_valid_in_reset", longint'(bus.out_valid), 0);
                check_val("abort_data_in_reset", longint'(bus.out_data), 0);
                break;
            end
            bus.srt_in = (s < ns);
            bus.in1 = (s < ns) ? pix(mode, s / I_SIZE, s % I_SIZE) : 16'sd0;
            bus.in2 = (s >= 1 && s - 1 < ns) ? pix(mode, (s - 1) / I_SIZE + 1, (s - 1) % I_SIZE) : 16'sd0;
            bus.in3 = (s >= 2 && s - 2 < ns) ? pix(mode, (s - 2) / I_SIZE + 2, (s - 2) % I_SIZE) : 16'sd0;
            bus.w_we = junk_we && (s >= 1);
            bus.w_in = 16'(s * 7 + 3);
            t1_tab[s] = cyc + 1;
            step();
        end
        idle_inputs();
        repeat (12) step();
    endtask

    task automatic check_frame(input int kind, input string name);
        int r;
        int c;
        int last_t1;
        int dc;
        check_val({name, "_count"}, q_data.size(), NOUT);
        for (int n = 0; n < q_data.size() && n < NOUT; n++) begin
            r = n / NB;
            c = n % NB;
            $display("%s out row=%0d col=%0d data=%0d cyc=%0d", name, q_row[n], q_col[n], q_data[n], q_cyc[n]);
            check_val({name, "_data"}, q_data[n], exp_out(kind, r, c));
            check_val({name, "_row"}, q_row[n], r);
            check_val({name, "_col"}, q_col[n], c);
            check_val({name, "_latency"}, q_cyc[n], t1_tab[r * I_SIZE + c + 2] + 4);
        end
        last_t1 = t1_tab[(NB - 1) * I_SIZE + I_SIZE - 1];
        dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
        check_val({name, "_done_count"}, done_cyc.size(), 1);
        check_val({name, "_done_cycle"}, dc, last_t1 + 5);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        check_val("rst_out_valid", longint'(bus.out_valid), 0);
        check_val("rst_out_data", longint'(bus.out_data), 0);
        check_val("rst_out_row", longint'(bus.out_row), 0);
        check_val("rst_out_col", longint'(bus.out_col), 0);
        check_val("rst_done", longint'(bus.done), 0);
        rst_n = 1'b1;
        step();
        clear_q();

        load_ident();
        run_frame(0, -1, 1'b0);
        check_frame(K_IDENT, "ident");
        check_val("ident_hold_data", longint'(bus.out_data), exp_out(K_IDENT, NB - 1, NB - 1));

        do_reset();
        load_const(1);
        run_frame(1, -1, 1'b0);
        check_frame(K_ONES, "ones");

        do_reset();
        load_const(32767);
        run_frame(2, -1, 1'b0);
        check_frame(K_SATP, "satp");

        do_reset();
        load_const(-32768);
        run_frame(2, -1, 1'b0);
        check_frame(K_SATN, "satn");

        do_reset();
        load_ident();
        run_frame(0, 1 * I_SIZE + 3, 1'b0);
        $display("abort outputs_after_reset=%0d done_pulses=%0d", q_data.size(), done_cyc.size());
        check_val("abort_outputs", q_data.size(), 0);
        check_val("abort_done", done_cyc.size(), 0);
        check_val("abort_out_data", longint'(bus.out_data), 0);

        do_reset();
        load_ident();
        run_frame(0, -1, 1'b0);
        check_frame(K_IDENT, "rerun");

        do_reset();
        for (int v = 1; v <= 10; v++) write_word(v);
        run_frame(0, -1, 1'b0);
        check_frame(K_WLOAD, "wload");

        do_reset();
        load_ident();
        run_frame(0, -1, 1'b1);
        check_frame(K_IDENT, "we_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_sa.md
CONV3X3_SA -- requirements
Module: conv3x3_sa

Interface
REQ-001 Parameter SIZE, default 7, unpadded image side; matches the upstream row-feeder.
REQ-002 Parameter PAD, default 0, zero-pad width; padded side I_SIZE = SIZE+2*PAD.
REQ-003 clk  input  1  single clock; all state on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 srt_in  input  1  high when in1 carries a valid column sample.
REQ-006 in1  input  16  signed lane 1, padded row r, column k, at cycle t1(k).
REQ-007 in2  input  16  signed lane 2, row r+1, column k, at t1(k)+1.
REQ-008 in3  input  16  signed lane 3, row r+2, column k, at t1(k)+2.
REQ-009 w_we  input  1  weight write strobe, one word per cycle.
REQ-010 w_in  input  16  signed kernel word, row-major W[0][0]..W[2][2].
REQ-011 out_valid  output  1  out_data holds a conv result.
REQ-012 out_data  output  32  signed saturated 3x3 convolution result.
REQ-013 out_row, out_col  output  8 each  output coordinates of out_data.
REQ-014 done  output  1  one-cycle pulse after the last result of a frame.

Function
REQ-015 Result O[r][c] = sum over i,j in 0..2 of W[i][j]*X[r+i][c+j], for r, c in 0..I_SIZE-3.
REQ-016 Internally de-skew lanes: delay in1 by 2 cycles and in2 by 1, then keep a 3-tap column shift register per lane.
REQ-017 Column counter counts srt_in-high cycles and wraps at I_SIZE-1->0; band counter r increments on each wrap.
REQ-018 Result valid for column counts k >= 2 only, with c = k-2; k = 0 and k = 1 of each band produce no output.
REQ-019 Latency: O[r][c] appears with out_valid=1 exactly at cycle t1(c+2)+4.
REQ-020 Products 16x16 -> 32-bit signed; 9-term sum in 36-bit signed; clamp to [-2^31, 2^31-1] on output.
REQ-021 FSM states IDLE, RUN, DRAIN.
REQ-022 IDLE -> RUN on srt_in=1.
REQ-023 RUN -> DRAIN when the band counter reaches I_SIZE-2 or srt_in falls.
REQ-024 DRAIN lasts 4 cycles, then done=1 for one cycle, then IDLE with the column and band counters cleared.
REQ-025 Weight index 0..8 advances on each accepted w_we and wraps 8->0.
REQ-026 w_we is accepted only in IDLE; it is ignored in RUN and DRAIN.
REQ-027 srt_in low mid-band in RUN: no further outputs for that band; drain outputs already in flight.
REQ-028 out_valid=0 cycles: out_data, out_row, out_col hold their previous values.

Reset
REQ-029 On rst_n=0, immediately: FSM IDLE; counters and weight index 0; all weights, pipeline and tap registers 0.
REQ-030 On rst_n=0, immediately: out_valid=0, out_data=0, out_row=0, out_col=0, done=0.
REQ-031 Reset mid-frame discards all in-flight results; no done pulse.

Structure
REQ-032 Package cnn_pkg holds DATA_W=16, PROD_W=32, ACC_W=36, OUT_W=32, KER=3, and the FSM state enum.
REQ-033 Sub-module sa_pe: one registered signed 16x16 multiplier, instantiated 9 times.
REQ-034 Adder tree and saturation are registered once, at the latency point fixed in REQ-019.

Verification
REQ-035 SIZE=5, PAD=0, W[1][1]=1, other weights 0, image X=10*row+col -> 9 outputs; O[r][c] = 10*(r+1)+(c+1); done one cycle after O[2][2].
REQ-036 All weights 1, image all 1 -> every out_data=9; exactly 9 out_valid cycles; latency t1(c+2)+4 checked for each.
REQ-037 All weights 32767, image all 32767 -> out_data=2147483647. Weights -32768, image 32767 -> out_data=-2147483648.
REQ-038 rst_n low for 1 cycle at band 1, column 3 -> outputs stop, no done pulse; rerun of the REQ-035 case gives the same results.
REQ-039 10 w_we words 1..10 -> W[0][0]=10, W[0][1]..W[2][2]=2..9.
REQ-040 w_we pulsed during RUN is ignored: results unchanged from the REQ-035 case.
